// File: rtl/dram_line_writer.sv
// -----------------------------------------------------------------------------
// dram_line_writer
//
// Collects {byte address, data word} updates from an input FIFO and merges
// them into one line buffer of WORDS_PER_LINE 32-bit words. Each line goes out
// as a single burst on the write-master control/user-buffer interface, with
// per-byte enables for the words that were written. A partial line is flushed
// when the next update belongs to another line (tag change), after
// FLUSH_TIMEOUT idle cycles, or on flush_req. An update that causes a tag
// change is held and replayed once the burst completes, so updates are never
// lost or reordered.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   dram_fifo_writedata/_write   update push ([63:32] byte addr, [31:0] data)
//   dram_fifo_full               input FIFO full
//   flush_req                    pulse: flush the current partial line
//   line_pending                 line buffer holds at least one valid word
//   control_*                    write-master control (go, base, length)
//   user_write_buffer            one-cycle push of the whole line
//   user_buffer_input_data       line data, word i at [32i+31:32i]
//   user_buffer_byteenable       4 enable bits per valid word
//   user_buffer_full             master buffer full (stalls the push)
//
// Optional feature macro: DRAM_LINE_WRITER_STATS_EN
//   When defined, adds stat_full_lines, stat_partial_lines and
//   stat_tag_evictions (32-bit, wrapping, cleared by reset), bumped when a
//   burst is issued according to what caused it.
// -----------------------------------------------------------------------------
module dram_line_writer #(
    parameter logic [30:0] DDR_BASE       = 31'h00000000,
    parameter int          ADDRESS_WIDTH  = 31,
    parameter int          WORDS_PER_LINE = 8,
    parameter int          FIFO_DEPTH     = 2048,
    parameter int          FLUSH_TIMEOUT  = 1024
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [63:0]                   dram_fifo_writedata,
    input  logic                          dram_fifo_write,
    output logic                          dram_fifo_full,
    input  logic                          flush_req,
    output logic                          line_pending,
    output logic                          control_fixed_location,
    output logic [ADDRESS_WIDTH-1:0]      control_write_base,
    output logic [ADDRESS_WIDTH-1:0]      control_write_length,
    output logic                          control_go,
    input  logic                          control_done,
    output logic                          user_write_buffer,
    output logic [32*WORDS_PER_LINE-1:0]  user_buffer_input_data,
    output logic [4*WORDS_PER_LINE-1:0]   user_buffer_byteenable,
    input  logic                          user_buffer_full
`ifdef DRAM_LINE_WRITER_STATS_EN
    ,
    output logic [31:0]                   stat_full_lines,
    output logic [31:0]                   stat_partial_lines,
    output logic [31:0]                   stat_tag_evictions
`endif
);

    localparam int L      = $clog2(WORDS_PER_LINE);
    localparam int TAG_W  = 30 - L;
    localparam int DATA_W = 32 * WORDS_PER_LINE;
    localparam int BE_W   = 4 * WORDS_PER_LINE;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [PTR_W-1:0]          PTR_LAST     = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]          CNT_FULL     = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]               TIMEOUT_LAST = 32'(FLUSH_TIMEOUT) - 32'd1;
    localparam logic [WORDS_PER_LINE-1:0] MASK_ZERO    = {WORDS_PER_LINE{1'b0}};
    localparam logic [1:0]                CAUSE_NONE    = 2'd0;
    localparam logic [1:0]                CAUSE_FULL    = 2'd1;
    localparam logic [1:0]                CAUSE_PARTIAL = 2'd2;
    localparam logic [1:0]                CAUSE_EVICT   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_MERGE     = 3'd2,
        S_ISSUE     = 3'd3,
        S_WRITE     = 3'd4,
        S_WAIT_DONE = 3'd5
    } state_t;

    // Line byte address: tag placed above the line offset, plus the DDR base.
    function automatic logic [ADDRESS_WIDTH-1:0] line_base(input logic [TAG_W-1:0] tag);
        logic [31:0] sum;
        sum = {tag, {(L + 2){1'b0}}} + {1'b0, DDR_BASE};
        return ADDRESS_WIDTH'(sum);
    endfunction

    // Each valid-word bit becomes four byte enables.
    function automatic logic [BE_W-1:0] expand_mask(input logic [WORDS_PER_LINE-1:0] m);
        logic [BE_W-1:0] be;
        be = {BE_W{1'b0}};
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            be[4*i +: 4] = {4{m[i]}};
        end
        return be;
    endfunction

    // FIFO keeps only the word address (addr[31:2]) and the data word.
    logic [61:0]        fifo_mem [FIFO_DEPTH];
    logic [61:0]        fifo_rdata_q;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               fifo_full_q, fifo_full_d;
    logic               fifo_wr_s, fifo_rd_s, fifo_empty_s;

    state_t                    state_q, state_d;
    logic [29:0]               entry_addr_q, entry_addr_d;
    logic [31:0]               entry_data_q, entry_data_d;
    logic [DATA_W-1:0]         data_q, data_d;
    logic [WORDS_PER_LINE-1:0] mask_q, mask_d;
    logic [TAG_W-1:0]          tag_q, tag_d;
    logic                      held_q, held_d;
    logic [31:0]               tcnt_q, tcnt_d;
    logic                      go_q, go_d;
    logic [ADDRESS_WIDTH-1:0]  base_q, base_d;
    logic                      wr_q, wr_d;
    logic [BE_W-1:0]           be_q, be_d;
    logic                      pending_q, pending_d;
    logic [1:0]                cause_s;
    logic                      timeout_hit_s;
    logic [L-1:0]              merge_off_s;
    logic [TAG_W-1:0]          merge_tag_s;

    assign fifo_empty_s = (count_q == {CNT_W{1'b0}});
    assign merge_off_s  = entry_addr_q[L-1:0];
    assign merge_tag_s  = entry_addr_q[29:L];

    // FIFO pointer/occupancy next-state.
    always_comb begin
        fifo_wr_s = dram_fifo_write && !fifo_full_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (fifo_wr_s) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (fifo_rd_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({fifo_wr_s, fifo_rd_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        fifo_full_d = (count_d == CNT_FULL);
    end

    // FIFO storage and one-cycle read port (no reset so it maps to RAM).
    always_ff @(posedge clk) begin
        if (fifo_wr_s) begin
            fifo_mem[wr_ptr_q] <= {dram_fifo_writedata[63:34], dram_fifo_writedata[31:0]};
        end
        if (fifo_rd_s) begin
            fifo_rdata_q <= fifo_mem[rd_ptr_q];
        end
    end

    // Timeout only fires with a partial line and the feature enabled.
    always_comb begin
        timeout_hit_s = (FLUSH_TIMEOUT != 0) && (mask_q != MASK_ZERO) && (tcnt_q == TIMEOUT_LAST);
    end

    // Line-writer FSM next-state and datapath.
    always_comb begin
        state_d      = state_q;
        fifo_rd_s    = 1'b0;
        entry_addr_d = entry_addr_q;
        entry_data_d = entry_data_q;
        data_d       = data_q;
        mask_d       = mask_q;
        tag_d        = tag_q;
        held_d       = held_q;
        cause_s      = CAUSE_NONE;
        case (state_q)
            S_IDLE: begin
                if (flush_req && (mask_q != MASK_ZERO)) begin
                    state_d = S_ISSUE;
                    cause_s = CAUSE_PARTIAL;
                end else if (!fifo_empty_s) begin
                    fifo_rd_s = 1'b1;
                    state_d   = S_FETCH;
                end else if (timeout_hit_s) begin
                    state_d = S_ISSUE;
                    cause_s = CAUSE_PARTIAL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                entry_addr_d = fifo_rdata_q[61:32];
                entry_data_d = fifo_rdata_q[31:0];
                state_d      = S_MERGE;
            end
            S_MERGE: begin
                // Different line already open: write it out first, keep entry.
                if ((mask_q != MASK_ZERO) && (merge_tag_s != tag_q)) begin
                    held_d  = 1'b1;
                    state_d = S_ISSUE;
                    cause_s = CAUSE_EVICT;
                end else begin
                    data_d[32*merge_off_s +: 32] = entry_data_q;
                    mask_d[merge_off_s]          = 1'b1;
                    tag_d                        = merge_tag_s;
                    if (&mask_d) begin
                        state_d = S_ISSUE;
                        cause_s = CAUSE_FULL;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (!user_buffer_full) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WAIT_DONE: begin
                if (control_done) begin
                    mask_d = MASK_ZERO;
                    data_d = {DATA_W{1'b0}};
                    if (held_q) begin
                        held_d  = 1'b0;
                        state_d = S_MERGE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_WAIT_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Idle counter and registered output next-values.
    always_comb begin
        if ((state_q == S_IDLE) && (state_d == S_IDLE)) begin
            if ((mask_q != MASK_ZERO) && fifo_empty_s && (tcnt_q != 32'hFFFF_FFFF)) begin
                tcnt_d = tcnt_q + 32'd1;
            end else begin
                tcnt_d = tcnt_q;
            end
        end else begin
            tcnt_d = 32'd0;
        end
        go_d = (state_d == S_ISSUE);
        if (state_d == S_ISSUE) begin
            base_d = line_base(tag_d);
        end else begin
            base_d = base_q;
        end
        wr_d      = (state_q == S_WRITE) && !user_buffer_full;
        be_d      = expand_mask(mask_d);
        pending_d = (mask_d != MASK_ZERO);
    end

    // State, line buffer, FIFO control and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            fifo_full_q  <= 1'b0;
            entry_addr_q <= 30'd0;
            entry_data_q <= 32'd0;
            data_q       <= {DATA_W{1'b0}};
            mask_q       <= MASK_ZERO;
            tag_q        <= {TAG_W{1'b0}};
            held_q       <= 1'b0;
            tcnt_q       <= 32'd0;
            go_q         <= 1'b0;
            base_q       <= {ADDRESS_WIDTH{1'b0}};
            wr_q         <= 1'b0;
            be_q         <= {BE_W{1'b0}};
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            fifo_full_q  <= fifo_full_d;
            entry_addr_q <= entry_addr_d;
            entry_data_q <= entry_data_d;
            data_q       <= data_d;
            mask_q       <= mask_d;
            tag_q        <= tag_d;
            held_q       <= held_d;
            tcnt_q       <= tcnt_d;
            go_q         <= go_d;
            base_q       <= base_d;
            wr_q         <= wr_d;
            be_q         <= be_d;
            pending_q    <= pending_d;
        end
    end

    assign dram_fifo_full         = fifo_full_q;
    assign line_pending           = pending_q;
    assign control_fixed_location = 1'b0;
    assign control_write_base     = base_q;
    assign control_write_length   = ADDRESS_WIDTH'(4 * WORDS_PER_LINE);
    assign control_go             = go_q;
    assign user_write_buffer      = wr_q;
    assign user_buffer_input_data = data_q;
    assign user_buffer_byteenable = be_q;

`ifdef DRAM_LINE_WRITER_STATS_EN
    logic [31:0] stat_full_q, stat_partial_q, stat_evict_q;
    logic        unused_ok_s;
    assign unused_ok_s = ^dram_fifo_writedata[33:32];

    // Per-cause burst counters, bumped on entry to ISSUE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_full_q    <= 32'd0;
            stat_partial_q <= 32'd0;
            stat_evict_q   <= 32'd0;
        end else begin
            case (cause_s)
                CAUSE_FULL:    stat_full_q    <= stat_full_q + 32'd1;
                CAUSE_PARTIAL: stat_partial_q <= stat_partial_q + 32'd1;
                CAUSE_EVICT:   stat_evict_q   <= stat_evict_q + 32'd1;
                default:       stat_full_q    <= stat_full_q;
            endcase
        end
    end

    assign stat_full_lines    = stat_full_q;
    assign stat_partial_lines = stat_partial_q;
    assign stat_tag_evictions = stat_evict_q;
`else
    logic unused_ok_s;
    assign unused_ok_s = ^{dram_fifo_writedata[33:32], cause_s};
`endif

endmodule

// File: tb/tb_dram_line_writer.sv
module tb_dram_line_writer;

    logic         clk = 1'b0;
    logic         reset_n;

    // Instance A: 8-word lines, base 0, short timeout
    logic [63:0]  a_wdata;
    logic         a_write, a_full, a_flush, a_pending, a_fixed, a_go, a_done, a_wr, a_ubfull;
    logic [30:0]  a_base, a_len;
    logic [255:0] a_data;
    logic [31:0]  a_be;

    // Instance B: 4-word lines, base 0x1000
    logic [63:0]  b_wdata;
    logic         b_write, b_full, b_flush, b_pending, b_fixed, b_go, b_done, b_wr, b_ubfull;
    logic [30:0]  b_base, b_len;
    logic [127:0] b_data;
    logic [15:0]  b_be;

    int total = 0;
    int bad   = 0;
    int go_cnt = 0;
    int wr_cnt = 0;
    logic [30:0]  go_base = 31'd0;
    logic [255:0] wr_data = 256'd0;
    logic [31:0]  wr_be   = 32'd0;

    always #5 clk = ~clk;

    dram_line_writer #(.FLUSH_TIMEOUT(16)) u_dut_a (
        .clk(clk), .reset_n(reset_n),
        .dram_fifo_writedata(a_wdata), .dram_fifo_write(a_write), .dram_fifo_full(a_full),
        .flush_req(a_flush), .line_pending(a_pending),
        .control_fixed_location(a_fixed), .control_write_base(a_base),
        .control_write_length(a_len), .control_go(a_go), .control_done(a_done),
        .user_write_buffer(a_wr), .user_buffer_input_data(a_data),
        .user_buffer_byteenable(a_be), .user_buffer_full(a_ubfull)
    );

    dram_line_writer #(.WORDS_PER_LINE(4), .DDR_BASE(31'h00001000)) u_dut_b (
        .clk(clk), .reset_n(reset_n),
        .dram_fifo_writedata(b_wdata), .dram_fifo_write(b_write), .dram_fifo_full(b_full),
        .flush_req(b_flush), .line_pending(b_pending),
        .control_fixed_location(b_fixed), .control_write_base(b_base),
        .control_write_length(b_len), .control_go(b_go), .control_done(b_done),
        .user_write_buffer(b_wr), .user_buffer_input_data(b_data),
        .user_buffer_byteenable(b_be), .user_buffer_full(b_ubfull)
    );

    // Record bursts seen on instance A
    always @(negedge clk) begin
        if (a_go) begin
            go_cnt  = go_cnt + 1;
            go_base = a_base;
        end
        if (a_wr) begin
            wr_cnt  = wr_cnt + 1;
            wr_data = a_data;
            wr_be   = a_be;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [31:0] addr, input logic [31:0] data);
        a_wdata = {addr, data};
        a_write = 1'b1;
        tick();
        a_write = 1'b0;
    endtask

    task automatic push_b(input logic [31:0] addr, input logic [31:0] data);
        b_wdata = {addr, data};
        b_write = 1'b1;
        tick();
        b_write = 1'b0;
    endtask

    task automatic wait_go(input int start, input string tag);
        int n = 0;
        while (go_cnt == start && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 256'(go_cnt - start), 256'(1));
    endtask

    task automatic wait_wr(input int start, input string tag);
        int n = 0;
        while (wr_cnt == start && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 256'(wr_cnt - start), 256'(1));
    endtask

    task automatic wait_pending(input string tag);
        int n = 0;
        while (!a_pending && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 256'(a_pending), 256'(1));
    endtask

    task automatic done_a();
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
    endtask

    task automatic flush_a();
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
    endtask

    initial begin
        int g0, w0, n;
        reset_n = 1'b0;
        a_wdata = 64'd0; a_write = 1'b0; a_flush = 1'b0; a_done = 1'b0; a_ubfull = 1'b0;
        b_wdata = 64'd0; b_write = 1'b0; b_flush = 1'b0; b_done = 1'b0; b_ubfull = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_go",      256'(a_go),      256'(0));
        chk("rst_wr",      256'(a_wr),      256'(0));
        chk("rst_base",    256'(a_base),    256'(0));
        chk("rst_be",      256'(a_be),      256'(0));
        chk("rst_data",    a_data,          256'(0));
        chk("rst_pending", 256'(a_pending), 256'(0));
        chk("rst_full",    256'(a_full),    256'(0));
        chk("rst_fixed",   256'(a_fixed),   256'(0));
        chk("rst_len",     256'(a_len),     256'(32));
        chk("rst_len_b",   256'(b_len),     256'(16));
        reset_n = 1'b1;
        tick();

        // Full line 0x100..0x11C, data 1..8
        g0 = go_cnt; w0 = wr_cnt;
        for (int i = 0; i < 8; i++) push_a(32'h100 + 32'(4 * i), 32'(i + 1));
        wait_go(g0, "t1_go");
        wait_wr(w0, "t1_wr");
        chk("t1_base", 256'(go_base), 256'h100);
        chk("t1_be",   256'(wr_be),   256'hFFFF_FFFF);
        chk("t1_data", wr_data,
            256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
        done_a();
        chk("t1_pending", 256'(a_pending), 256'(0));
        chk("t1_one_go", 256'(go_cnt - g0), 256'(1));

        // Tag change: 0x200/0x204 flushed, 0x300 held and replayed
        g0 = go_cnt; w0 = wr_cnt;
        push_a(32'h200, 32'hA);
        push_a(32'h204, 32'hB);
        push_a(32'h300, 32'hC);
        wait_go(g0, "t2_go");
        wait_wr(w0, "t2_wr");
        chk("t2_base", 256'(go_base), 256'h200);
        chk("t2_be",   256'(wr_be),   256'hFF);
        chk("t2_data", wr_data,       256'h0000000B_0000000A);
        done_a();
        tick();
        chk("t2_replay_pending", 256'(a_pending), 256'(1));
        g0 = go_cnt; w0 = wr_cnt;
        flush_a();
        wait_go(g0, "t2b_go");
        wait_wr(w0, "t2b_wr");
        chk("t2b_base", 256'(go_base), 256'h300);
        chk("t2b_be",   256'(wr_be),   256'hF);
        chk("t2b_data", wr_data,       256'hC);
        done_a();

        // Timeout flush after 16 idle cycles
        g0 = go_cnt; w0 = wr_cnt;
        push_a(32'h40C, 32'h55);
        wait_pending("t3_pending");
        n = 0;
        while (!a_go && n < 50) begin
            tick();
            n++;
        end
        chk("t3_delay", 256'(n), 256'(16));
        wait_wr(w0, "t3_wr");
        chk("t3_base", 256'(go_base), 256'h400);
        chk("t3_be",   256'(wr_be),   256'h0000_F000);
        chk("t3_data", wr_data,       256'h00000055_00000000_00000000_00000000);
        done_a();

        // Explicit flush, then flush of an empty line
        g0 = go_cnt; w0 = wr_cnt;
        push_a(32'h500, 32'h1);
        wait_pending("t4_pending");
        flush_a();
        wait_go(g0, "t4_go");
        wait_wr(w0, "t4_wr");
        chk("t4_base", 256'(go_base), 256'h500);
        chk("t4_be",   256'(wr_be),   256'hF);
        done_a();
        g0 = go_cnt;
        flush_a();
        repeat (10) tick();
        chk("t4_empty_flush", 256'(go_cnt - g0), 256'(0));

        // Back-pressure in WRITE, then reset during WAIT_DONE
        a_ubfull = 1'b1;
        g0 = go_cnt; w0 = wr_cnt;
        push_a(32'h600, 32'h7);
        wait_pending("t5_pending");
        flush_a();
        wait_go(g0, "t5_go");
        repeat (10) tick();
        chk("t5_held_wr", 256'(wr_cnt - w0), 256'(0));
        chk("t5_wr_low", 256'(a_wr), 256'(0));
        a_ubfull = 1'b0;
        wait_wr(w0, "t5_wr");
        chk("t5_be", 256'(wr_be), 256'hF);
        push_a(32'h700, 32'h9);
        reset_n = 1'b0;
        tick();
        chk("t5_rst_go",      256'(a_go),      256'(0));
        chk("t5_rst_wr",      256'(a_wr),      256'(0));
        chk("t5_rst_base",    256'(a_base),    256'(0));
        chk("t5_rst_be",      256'(a_be),      256'(0));
        chk("t5_rst_data",    a_data,          256'(0));
        chk("t5_rst_pending", 256'(a_pending), 256'(0));
        reset_n = 1'b1;
        repeat (8) tick();
        chk("t5_fifo_cleared", 256'(a_pending), 256'(0));
        g0 = go_cnt; w0 = wr_cnt;
        push_a(32'h900, 32'h3);
        wait_pending("t5_post_pending");
        flush_a();
        wait_go(g0, "t5_post_go");
        wait_wr(w0, "t5_post_wr");
        chk("t5_post_base", 256'(go_base), 256'h900);
        done_a();

        // 4-word lines with DDR_BASE 0x1000
        for (int i = 0; i < 4; i++) push_b(32'h20 + 32'(4 * i), 32'(i + 1));
        n = 0;
        while (!b_go && n < 100) begin
            tick();
            n++;
        end
        chk("b_go",   256'(b_go),   256'(1));
        chk("b_base", 256'(b_base), 256'h1020);
        chk("b_len",  256'(b_len),  256'(16));
        n = 0;
        while (!b_wr && n < 100) begin
            tick();
            n++;
        end
        chk("b_wr",   256'(b_wr),   256'(1));
        chk("b_be",   256'(b_be),   256'hFFFF);
        chk("b_data", 256'(b_data), 256'h00000004_00000003_00000002_00000001);
        b_done = 1'b1;
        tick();
        b_done = 1'b0;
        chk("b_pending", 256'(b_pending), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
